// File: rtl/connect4_pkg.sv
// Shared Connect-4 definitions: board geometry, detector status codes, sequencer states.
package connect4_pkg;

    localparam int BOARD_W = 16;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;

    typedef enum logic [1:0] {
        STILL_PLAYING = 2'b00,
        P1_WINS       = 2'b01,
        P2_WINS       = 2'b10,
        TIE           = 2'b11
    } status_t;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        PLACE,
        WAIT_STATUS,
        OVER
    } state_t;

    // Board bit index: row*4 + col, row 0 at the bottom.
    function automatic logic [3:0] cell_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/column_scan.sv
// Combinational search for the lowest empty row of one column.
module column_scan
    import connect4_pkg::*;
(
    input  logic [BOARD_W-1:0] game_board,
    input  logic [1:0]         col,
    output logic [1:0]         row,
    output logic               full
);

    // Walk top-down so the last empty cell seen is the lowest one.
    always_comb begin
        row  = '0;
        full = 1'b1;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!game_board[cell_idx(2'(r), col)]) begin
                row  = 2'(r);
                full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/move_sequencer.sv
// Connect-4 move sequencer: accepts column moves, drops pieces, waits on the win detector.
// Optional per-turn forfeit timer enabled by defining MOVE_TIMEOUT_EN.
module move_sequencer
    import connect4_pkg::*;
#(
    parameter int STATUS_WAIT    = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               new_game,
    input  logic               move_valid,
    input  logic [1:0]         move_col,
    input  logic [1:0]         game_status,
    output logic               move_ready,
    output logic [BOARD_W-1:0] game_board,
    output logic [BOARD_W-1:0] player_cells,
    output logic               current_player,
    output logic               move_reject,
    output logic               game_over,
    output logic               turn_timeout
);

    if (STATUS_WAIT < 1 || STATUS_WAIT > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("move_sequencer: STATUS_WAIT or TIMEOUT_CYCLES out of range");
    end

    state_t     state;
    logic [1:0] col_q;
    logic [1:0] row_q;
    logic [3:0] wait_cnt;
    logic [1:0] scan_row;
    logic       scan_full;
    logic       accept;

    assign accept = move_valid & move_ready;

    column_scan u_scan (
        .game_board (game_board),
        .col        (col_q),
        .row        (scan_row),
        .full       (scan_full)
    );

`ifdef MOVE_TIMEOUT_EN
    logic [15:0] turn_timer;
`else
    assign turn_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            game_board     <= '0;
            player_cells   <= '0;
            current_player <= 1'b0;
            move_ready     <= 1'b1;
            move_reject    <= 1'b0;
            game_over      <= 1'b0;
            col_q          <= '0;
            row_q          <= '0;
            wait_cnt       <= '0;
`ifdef MOVE_TIMEOUT_EN
            turn_timer     <= '0;
            turn_timeout   <= 1'b0;
`endif
        end else if (new_game) begin
            // Restart wins over anything in flight, including a PLACE write.
            state          <= IDLE;
            game_board     <= '0;
            player_cells   <= '0;
            current_player <= 1'b0;
            move_ready     <= 1'b1;
            move_reject    <= 1'b0;
            game_over      <= 1'b0;
            wait_cnt       <= '0;
`ifdef MOVE_TIMEOUT_EN
            turn_timer     <= '0;
            turn_timeout   <= 1'b0;
`endif
        end else begin
            move_reject <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            turn_timeout <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // Also re-arms ready one cycle after a reject.
                    move_ready <= 1'b1;
                    if (accept) begin
                        col_q      <= move_col;
                        move_ready <= 1'b0;
                        state      <= SCAN;
`ifdef MOVE_TIMEOUT_EN
                        turn_timer <= '0;
`endif
                    end
`ifdef MOVE_TIMEOUT_EN
                    else if (turn_timer == 16'(TIMEOUT_CYCLES - 1)) begin
                        turn_timeout   <= 1'b1;
                        current_player <= ~current_player;
                        turn_timer     <= '0;
                    end else begin
                        turn_timer <= turn_timer + 16'd1;
                    end
`endif
                end
                SCAN: begin
                    if (scan_full) begin
                        move_reject <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        row_q <= scan_row;
                        state <= PLACE;
                    end
                end
                PLACE: begin
                    if (!game_board[cell_idx(row_q, col_q)]) begin
                        game_board[cell_idx(row_q, col_q)]   <= 1'b1;
                        player_cells[cell_idx(row_q, col_q)] <= current_player;
                    end
                    wait_cnt <= 4'(STATUS_WAIT);
                    state    <= WAIT_STATUS;
                end
                WAIT_STATUS: begin
                    if (wait_cnt == 4'd0) begin
                        if (status_t'(game_status) != STILL_PLAYING) begin
                            game_over <= 1'b1;
                            state     <= OVER;
                        end else begin
                            current_player <= ~current_player;
                            move_ready     <= 1'b1;
                            state          <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                OVER: begin
                    move_ready <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
